// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: receive side of a scanned multi-digit 7-segment bus.
// Samples seg/an, waits for each digit dwell to be stable for STABLE_CYCLES
// samples, decodes the segment pattern back to BCD and stores one nibble per digit.
// Optional macro SEG7_RX_HEX_EN: extends the decode table with hex glyphs A..F.
module seg7_scan_reader #(
    parameter int unsigned N_DIGITS      = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg,
    input  logic [N_DIGITS-1:0]     an,
    output logic [4*N_DIGITS-1:0]   bcd_out,
    output logic [N_DIGITS-1:0]     digit_valid,
    output logic [N_DIGITS-1:0]     digit_err,
    output logic                    new_digit,
    output logic                    frame_done
);

    localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        HOLD
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [6:0]              s_seg_q, s_seg_d;
    logic [N_DIGITS-1:0]     s_an_q, s_an_d;
    logic [6:0]              prev_seg_q, prev_seg_d;
    logic [N_DIGITS-1:0]     prev_an_q, prev_an_d;
    logic [4*N_DIGITS-1:0]   bcd_q, bcd_d;
    logic [N_DIGITS-1:0]     valid_q, valid_d;
    logic [N_DIGITS-1:0]     err_q, err_d;
    logic [N_DIGITS-1:0]     mask_q, mask_d;
    logic                    new_digit_q, new_digit_d;
    logic                    frame_done_q, frame_done_d;

    logic                    onehot;
    logic                    same;
    logic                    capture;
    logic [4:0]              dec;

    // Returns {err, nibble}; anything not in the table decodes to {1, F}.
    function automatic logic [4:0] seg_decode(input logic [6:0] s);
        logic [4:0] r;
        r = {1'b1, 4'hF};
        case (s)
            7'b1111110: r = {1'b0, 4'h0};
            7'b0110000: r = {1'b0, 4'h1};
            7'b1101101: r = {1'b0, 4'h2};
            7'b1111001: r = {1'b0, 4'h3};
            7'b0110011: r = {1'b0, 4'h4};
            7'b1011011: r = {1'b0, 4'h5};
            7'b1011111: r = {1'b0, 4'h6};
            7'b1110000: r = {1'b0, 4'h7};
            7'b1111111: r = {1'b0, 4'h8};
            7'b1111011: r = {1'b0, 4'h9};
`ifdef SEG7_RX_HEX_EN
            7'b1110111: r = {1'b0, 4'hA};
            7'b0011111: r = {1'b0, 4'hB};
            7'b1001110: r = {1'b0, 4'hC};
            7'b0111101: r = {1'b0, 4'hD};
            7'b1001111: r = {1'b0, 4'hE};
            7'b1000111: r = {1'b0, 4'hF};
`endif
            default:    r = {1'b1, 4'hF};
        endcase
        return r;
    endfunction

    assign onehot = (s_an_q != '0) && ((s_an_q & (s_an_q - N_DIGITS'(1))) == '0);
    assign same   = ({s_an_q, s_seg_q} == {prev_an_q, prev_seg_q});

    // Dwell tracker: counts consecutive identical samples and flags one capture per dwell.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        capture    = 1'b0;
        s_seg_d    = seg;
        s_an_d     = an;
        prev_seg_d = s_seg_q;
        prev_an_d  = s_an_q;
        case (state_q)
            IDLE: begin
                if (onehot) begin
                    state_d = TRACK;
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            TRACK: begin
                if (!onehot) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    cnt_d   = CW'(1);
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                end
            end
            HOLD: begin
                if (!same) begin
                    if (onehot) begin
                        state_d = TRACK;
                        cnt_d   = CW'(1);
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Capture on the sample that completes the stable run, including a
        // first sample when STABLE_CYCLES is 1.
        if (state_d == TRACK && cnt_d == CW'(STABLE_CYCLES)) begin
            capture = 1'b1;
            state_d = HOLD;
        end
    end

    // Capture datapath: store decoded nibble in the enabled slot and track frame completion.
    always_comb begin
        bcd_d        = bcd_q;
        valid_d      = valid_q;
        err_d        = err_q;
        mask_d       = mask_q;
        new_digit_d  = 1'b0;
        frame_done_d = 1'b0;
        dec          = seg_decode(s_seg_q);
        if (capture) begin
            for (int unsigned i = 0; i < N_DIGITS; i++) begin
                if (s_an_q[i]) begin
                    bcd_d[4*i +: 4] = dec[3:0];
                    err_d[i]        = dec[4];
                end
            end
            valid_d     = valid_q | s_an_q;
            mask_d      = mask_q | s_an_q;
            new_digit_d = 1'b1;
            if (&mask_d) begin
                frame_done_d = 1'b1;
                mask_d       = '0;
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            s_seg_q      <= '0;
            s_an_q       <= '0;
            prev_seg_q   <= '0;
            prev_an_q    <= '0;
            bcd_q        <= '0;
            valid_q      <= '0;
            err_q        <= '0;
            mask_q       <= '0;
            new_digit_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            s_seg_q      <= s_seg_d;
            s_an_q       <= s_an_d;
            prev_seg_q   <= prev_seg_d;
            prev_an_q    <= prev_an_d;
            bcd_q        <= bcd_d;
            valid_q      <= valid_d;
            err_q        <= err_d;
            mask_q       <= mask_d;
            new_digit_q  <= new_digit_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_valid = valid_q;
    assign digit_err   = err_q;
    assign new_digit   = new_digit_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader (N_DIGITS=4, STABLE_CYCLES=4).
// Honours SEG7_RX_HEX_EN when choosing the expected decode of the 'A' glyph.
module tb_seg7_scan_reader;

    localparam logic [6:0] P0 = 7'b1111110;
    localparam logic [6:0] P1 = 7'b0110000;
    localparam logic [6:0] P2 = 7'b1101101;
    localparam logic [6:0] P3 = 7'b1111001;
    localparam logic [6:0] P4 = 7'b0110011;
    localparam logic [6:0] P5 = 7'b1011011;
    localparam logic [6:0] P6 = 7'b1011111;
    localparam logic [6:0] P7 = 7'b1110000;
    localparam logic [6:0] P8 = 7'b1111111;
    localparam logic [6:0] P9 = 7'b1111011;
    localparam logic [6:0] PA = 7'b1110111;

`ifdef SEG7_RX_HEX_EN
    localparam logic [3:0] EXP_A = 4'hA;
    localparam logic       ERR_A = 1'b0;
`else
    localparam logic [3:0] EXP_A = 4'hF;
    localparam logic       ERR_A = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg;
    logic [3:0]  an;
    logic [15:0] bcd_out;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_err;
    logic        new_digit;
    logic        frame_done;

    int vectors     = 0;
    int miscompares = 0;
    int nd_cnt, fd_cnt, fd_nd, first_nd, fd_step, steps;

    seg7_scan_reader #(.N_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg         (seg),
        .an          (an),
        .bcd_out     (bcd_out),
        .digit_valid (digit_valid),
        .digit_err   (digit_err),
        .new_digit   (new_digit),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic clr_counts();
        nd_cnt = 0; fd_cnt = 0; fd_nd = 0; first_nd = 0; fd_step = 0; steps = 0;
    endtask

    // Advance n cycles, sampling 1 time unit after each rising edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            steps++;
            if (new_digit === 1'b1) begin
                nd_cnt++;
                if (first_nd == 0) first_nd = steps;
            end
            if (frame_done === 1'b1) begin
                fd_cnt++;
                fd_step = steps;
                if (new_digit === 1'b1) fd_nd++;
            end
        end
    endtask

    task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
        an  = a;
        seg = s;
        step(n);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: reset state
        rst = 1'b1; an = 4'b0000; seg = 7'b0000000;
        clr_counts();
        step(2);
        chk("rst_bcd",   bcd_out, 16'h0000);
        chk("rst_valid", digit_valid, 4'b0000);
        chk("rst_err",   digit_err, 4'b0000);
        chk("rst_pulse", nd_cnt + fd_cnt, 0);

        // 2: single digit, capture latency
        rst = 1'b0;
        clr_counts();
        dwell(4'b0001, P2, 10);
        chk("t2_nd_cnt",  nd_cnt, 1);
        chk("t2_latency", first_nd, 5);
        chk("t2_nib0",    bcd_out[3:0], 4'h2);
        chk("t2_valid",   digit_valid, 4'b0001);
        chk("t2_err",     digit_err, 4'b0000);
        chk("t2_fd",      fd_cnt, 0);

        // 3: full scan 1,2,3,4
        clr_counts();
        dwell(4'b0001, P1, 6);
        dwell(4'b0010, P2, 6);
        dwell(4'b0100, P3, 6);
        dwell(4'b1000, P4, 6);
        chk("t3_nd_cnt",  nd_cnt, 4);
        chk("t3_fd_cnt",  fd_cnt, 1);
        chk("t3_fd_nd",   fd_nd, 1);
        chk("t3_fd_step", fd_step, 23);
        chk("t3_bcd",     bcd_out, 16'h4321);
        chk("t3_valid",   digit_valid, 4'b1111);
        chk("t3_err",     digit_err, 4'b0000);

        // 4: seg toggling faster than STABLE_CYCLES, then non-one-hot enables
        clr_counts();
        for (int r = 0; r < 3; r++) begin
            dwell(4'b0010, P5, 3);
            dwell(4'b0010, P6, 3);
        end
        chk("t4_toggle_nd", nd_cnt, 0);
        clr_counts();
        dwell(4'b0110, P8, 10);
        chk("t4_multi_nd", nd_cnt, 0);
        chk("t4_bcd",      bcd_out, 16'h4321);
        chk("t4_fd",       fd_cnt, 0);

        // 5: hex glyph A on digit 3
        clr_counts();
        dwell(4'b1000, PA, 10);
        chk("t5_nd_cnt", nd_cnt, 1);
        chk("t5_bcd",    bcd_out, {EXP_A, 12'h321});
        chk("t5_err",    digit_err, {ERR_A, 3'b000});
        chk("t5_fd",     fd_cnt, 0);

        // blank pattern is always invalid
        clr_counts();
        dwell(4'b0100, 7'b0000000, 10);
        chk("blank_nd",  nd_cnt, 1);
        chk("blank_bcd", bcd_out, {EXP_A, 12'hF21});
        chk("blank_err", digit_err, {ERR_A, 3'b100});

        // 6: reset mid-frame discards the partial frame
        rst = 1'b1;
        dwell(4'b0000, 7'b0000000, 2);
        rst = 1'b0;
        chk("t6_rst_bcd", bcd_out, 16'h0000);
        clr_counts();
        dwell(4'b0001, P0, 6);
        dwell(4'b0010, P8, 6);
        dwell(4'b0100, P9, 6);
        chk("t6_part_nd",    nd_cnt, 3);
        chk("t6_part_fd",    fd_cnt, 0);
        chk("t6_part_bcd",   bcd_out, 16'h0980);
        chk("t6_part_valid", digit_valid, 4'b0111);
        dwell(4'b1000, P7, 2);
        rst = 1'b1;
        step(2);
        chk("t6_mid_bcd",   bcd_out, 16'h0000);
        chk("t6_mid_valid", digit_valid, 4'b0000);
        chk("t6_mid_err",   digit_err, 4'b0000);
        chk("t6_mid_pulse", {30'd0, new_digit, frame_done}, 0);
        rst = 1'b0;
        clr_counts();
        step(10);
        chk("t6_post_latency", first_nd, 5);
        chk("t6_post_nd",      nd_cnt, 1);
        chk("t6_post_fd",      fd_cnt, 0);
        chk("t6_post_bcd",     bcd_out, 16'h7000);
        clr_counts();
        dwell(4'b0001, P0, 6);
        dwell(4'b0010, P8, 6);
        dwell(4'b0100, P9, 6);
        chk("t6_full_nd",    nd_cnt, 3);
        chk("t6_full_fd",    fd_cnt, 1);
        chk("t6_full_fd_nd", fd_nd, 1);
        chk("t6_full_bcd",   bcd_out, 16'h7980);
        chk("t6_full_valid", digit_valid, 4'b1111);
        chk("t6_full_err",   digit_err, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
